// File: rtl/posit_scale_if.sv
// Handshake and operand/result bundle between posit decoders, the scale combiner
// and the encode stage.
interface posit_scale_if #(
  parameter int unsigned ES     = 3,
  parameter int unsigned K_BITS = 6
);
  localparam int unsigned SCALE_W = ES + K_BITS + 1;

  logic                      in_valid;
  logic                      in_ready;
  logic                      op;
  logic signed [K_BITS-1:0]  k_A;
  logic signed [K_BITS-1:0]  k_B;
  logic        [ES-1:0]      exp_A;
  logic        [ES-1:0]      exp_B;
  logic                      sign_A;
  logic                      sign_B;
  logic                      nar_A;
  logic                      nar_B;
  logic                      zero_A;
  logic                      zero_B;

  logic                      out_valid;
  logic                      out_ready;
  logic signed [SCALE_W-1:0] scale_out;
  logic signed [K_BITS-1:0]  k_out;
  logic        [ES-1:0]      exp_out;
  logic                      sign_out;
  logic                      nar_out;
  logic                      zero_out;
  logic                      ovf;
  logic                      udf;

  modport slave (
    input  in_valid, op, k_A, k_B, exp_A, exp_B, sign_A, sign_B,
           nar_A, nar_B, zero_A, zero_B, out_ready,
    output in_ready, out_valid, scale_out, k_out, exp_out,
           sign_out, nar_out, zero_out, ovf, udf
  );

  modport master (
    output in_valid, op, k_A, k_B, exp_A, exp_B, sign_A, sign_B,
           nar_A, nar_B, zero_A, zero_B, out_ready,
    input  in_ready, out_valid, scale_out, k_out, exp_out,
           sign_out, nar_out, zero_out, ovf, udf
  );
endinterface

// File: rtl/posit_scale_unit.sv
// Combines two decoded posit scales (add for multiply, subtract for divide), clamps to
// the posit dynamic range and re-splits the result into regime/exponent form.
module posit_scale_unit #(
  parameter int unsigned N      = 32,
  parameter int unsigned ES     = 3,
  parameter int unsigned K_BITS = 6
) (
  input logic           clk,
  input logic           rst,
  posit_scale_if.slave  bus
);
  localparam int unsigned SCALE_W = ES + K_BITS + 1;
  localparam int          MaxScaleInt = (N - 2) * (2 ** ES);
  localparam logic signed [SCALE_W-1:0] MaxScale = SCALE_W'(MaxScaleInt);
  localparam logic signed [SCALE_W-1:0] MinScale = SCALE_W'(-MaxScaleInt);

  typedef enum logic [2:0] {StIdle, StLoad, StCombine, StClamp, StHold} state_e;
  state_e state_q, state_d;

  logic                      op_q;
  logic signed [K_BITS-1:0]  k_a_q, k_b_q;
  logic        [ES-1:0]      exp_a_q, exp_b_q;
  logic                      sign_a_q, sign_b_q, nar_a_q, nar_b_q, zero_a_q, zero_b_q;
  logic signed [SCALE_W-1:0] s_a_q, s_b_q, raw_q;
  logic                      sign_q;

  logic signed [SCALE_W-1:0] scale_q;
  logic signed [K_BITS-1:0]  k_out_q;
  logic        [ES-1:0]      exp_out_q;
  logic                      sign_out_q, nar_out_q, zero_out_q, ovf_q, udf_q;

  logic                      in_ready, out_valid;
  logic signed [SCALE_W-1:0] clamp_c;
  logic                      nar_c, zero_c, ovf_c, udf_c, sign_c;

  function automatic logic signed [SCALE_W-1:0] to_scale(logic signed [K_BITS-1:0] k,
                                                         logic [ES-1:0] e);
    logic signed [SCALE_W-1:0] kx;
    kx = {{(SCALE_W - K_BITS){k[K_BITS-1]}}, k};
    return (kx <<< ES) | {{(SCALE_W - ES){1'b0}}, e};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_d = StLoad;
      end
      StLoad:    state_d = StCombine;
      StCombine: state_d = StClamp;
      StClamp:   state_d = StHold;
      StHold: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_d = StIdle;
      end
      default:   state_d = StIdle;
    endcase
  end

  // Divide by zero is NaR; specials override every numeric result.
  always_comb begin
    nar_c   = nar_a_q | nar_b_q | (op_q & zero_b_q);
    zero_c  = ~nar_c & (zero_a_q | (~op_q & zero_b_q));
    clamp_c = raw_q;
    ovf_c   = 1'b0;
    udf_c   = 1'b0;
    sign_c  = sign_q;
    if (raw_q > MaxScale) begin
      clamp_c = MaxScale;
      ovf_c   = 1'b1;
    end else if (raw_q < MinScale) begin
      clamp_c = MinScale;
      udf_c   = 1'b1;
    end
    if (nar_c || zero_c) begin
      clamp_c = '0;
      ovf_c   = 1'b0;
      udf_c   = 1'b0;
      sign_c  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= 1'b0;
      k_a_q      <= '0;
      k_b_q      <= '0;
      exp_a_q    <= '0;
      exp_b_q    <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      nar_a_q    <= 1'b0;
      nar_b_q    <= 1'b0;
      zero_a_q   <= 1'b0;
      zero_b_q   <= 1'b0;
      s_a_q      <= '0;
      s_b_q      <= '0;
      raw_q      <= '0;
      sign_q     <= 1'b0;
      scale_q    <= '0;
      k_out_q    <= '0;
      exp_out_q  <= '0;
      sign_out_q <= 1'b0;
      nar_out_q  <= 1'b0;
      zero_out_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            op_q       <= bus.op;
            k_a_q      <= bus.k_A;
            k_b_q      <= bus.k_B;
            exp_a_q    <= bus.exp_A;
            exp_b_q    <= bus.exp_B;
            sign_a_q   <= bus.sign_A;
            sign_b_q   <= bus.sign_B;
            nar_a_q    <= bus.nar_A;
            nar_b_q    <= bus.nar_B;
            zero_a_q   <= bus.zero_A;
            zero_b_q   <= bus.zero_B;
            // Results of the previous operation never leak into the next one.
            scale_q    <= '0;
            k_out_q    <= '0;
            exp_out_q  <= '0;
            sign_out_q <= 1'b0;
            nar_out_q  <= 1'b0;
            zero_out_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
          end
        end
        StLoad: begin
          s_a_q <= to_scale(k_a_q, exp_a_q);
          s_b_q <= to_scale(k_b_q, exp_b_q);
        end
        StCombine: begin
          raw_q  <= op_q ? (s_a_q - s_b_q) : (s_a_q + s_b_q);
          sign_q <= sign_a_q ^ sign_b_q;
        end
        StClamp: begin
          scale_q    <= clamp_c;
          k_out_q    <= K_BITS'(clamp_c >>> ES);
          exp_out_q  <= clamp_c[ES-1:0];
          sign_out_q <= sign_c;
          nar_out_q  <= nar_c;
          zero_out_q <= zero_c;
          ovf_q      <= ovf_c;
          udf_q      <= udf_c;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.scale_out = scale_q;
  assign bus.k_out     = k_out_q;
  assign bus.exp_out   = exp_out_q;
  assign bus.sign_out  = sign_out_q;
  assign bus.nar_out   = nar_out_q;
  assign bus.zero_out  = zero_out_q;
  assign bus.ovf       = ovf_q;
  assign bus.udf       = udf_q;
endmodule

// File: tb/tb_posit_scale_unit.sv
// Directed and randomized bench for posit_scale_unit (N=32, ES=3) against an
// arithmetic reference model.
module tb_posit_scale_unit;
  localparam int LIM = 30 * 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  posit_scale_if #(.ES(3), .K_BITS(6)) bus ();

  posit_scale_unit #(.N(32), .ES(3), .K_BITS(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    int   scale;
    int   k;
    int   e;
    logic sign;
    logic nar;
    logic zero;
    logic ovf;
    logic udf;
  } res_t;

  function automatic res_t model(bit op, int ka, int ea, int kb, int eb, bit sa, bit sb,
                                 bit na, bit nb, bit za, bit zb);
    res_t r;
    int   raw;
    r = '0;
    raw = op ? (ka * 8 + ea) - (kb * 8 + eb) : (ka * 8 + ea) + (kb * 8 + eb);
    r.nar  = na | nb | (op & zb);
    r.zero = !r.nar && (za || (!op && zb));
    if (r.nar || r.zero) return r;
    r.scale = raw;
    if (raw > LIM) begin r.scale = LIM; r.ovf = 1'b1; end
    else if (raw < -LIM) begin r.scale = -LIM; r.udf = 1'b1; end
    r.e    = ((r.scale % 8) + 8) % 8;
    r.k    = (r.scale - r.e) / 8;
    r.sign = sa ^ sb;
    return r;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_outputs(input string tag, input res_t r);
    chk({tag, ".scale"}, 32'(bus.scale_out), r.scale);
    chk({tag, ".k"},     32'(bus.k_out),     r.k);
    chk({tag, ".exp"},   {29'd0, bus.exp_out}, r.e);
    chk({tag, ".sign"},  {31'd0, bus.sign_out}, {31'd0, r.sign});
    chk({tag, ".nar"},   {31'd0, bus.nar_out},  {31'd0, r.nar});
    chk({tag, ".zero"},  {31'd0, bus.zero_out}, {31'd0, r.zero});
    chk({tag, ".ovf"},   {31'd0, bus.ovf},      {31'd0, r.ovf});
    chk({tag, ".udf"},   {31'd0, bus.udf},      {31'd0, r.udf});
  endtask

  // Presents operands right after an edge; leaves the bench sampling in HOLD
  // (or after the timeout) with the result in 'r'.
  task automatic present(input string tag, input bit op, input int ka, input int ea,
                         input int kb, input int eb, input bit sa, input bit sb,
                         input bit na, input bit nb, input bit za, input bit zb,
                         output res_t r);
    int cnt;
    cnt = 0;
    while (bus.in_ready !== 1'b1 && cnt < 20) begin
      @(posedge clk); #1; cnt++;
    end
    chk({tag, ".idle_wait"}, {31'd0, bus.in_ready}, 32'd1);
    bus.op = op;
    bus.k_A = 6'(ka); bus.exp_A = 3'(ea); bus.k_B = 6'(kb); bus.exp_B = 3'(eb);
    bus.sign_A = sa; bus.sign_B = sb; bus.nar_A = na; bus.nar_B = nb;
    bus.zero_A = za; bus.zero_B = zb;
    bus.in_valid = 1'b1;
    r = model(op, ka, ea, kb, eb, sa, sb, na, nb, za, zb);
    cnt = 0;
    do begin
      @(posedge clk); #1; cnt++;
      if (cnt == 1) bus.in_valid = 1'b0;
      if (bus.out_valid === 1'b1 && bus.in_ready !== 1'b0) begin
        chk({tag, ".ready_valid_excl"}, {31'd0, bus.in_ready}, 32'd0);
      end
    end while (bus.out_valid !== 1'b1 && cnt < 20);
    chk({tag, ".latency"}, cnt, 4);
  endtask

  task automatic run_op(input string tag, input bit op, input int ka, input int ea,
                        input int kb, input int eb, input bit sa, input bit sb,
                        input bit na, input bit nb, input bit za, input bit zb);
    res_t r;
    present(tag, op, ka, ea, kb, eb, sa, sb, na, nb, za, zb, r);
    chk_outputs(tag, r);
    @(posedge clk); #1;
    chk({tag, ".back_idle"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    res_t r;
    logic [31:0] snap;
    int cnt;
    bus.in_valid = 1'b0; bus.op = 1'b0; bus.out_ready = 1'b1;
    bus.k_A = '0; bus.k_B = '0; bus.exp_A = '0; bus.exp_B = '0;
    bus.sign_A = 1'b0; bus.sign_B = 1'b0; bus.nar_A = 1'b0; bus.nar_B = 1'b0;
    bus.zero_A = 1'b0; bus.zero_B = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset.in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("reset.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk_outputs("reset", '0);

    run_op("mul",       1'b0,   1, 2,  -2, 5, 1'b0, 1'b1, 0, 0, 0, 0);
    run_op("div",       1'b1,   1, 2,  -2, 5, 1'b0, 1'b1, 0, 0, 0, 0);
    run_op("ovf",       1'b0,  29, 7,  29, 7, 1'b0, 1'b0, 0, 0, 0, 0);
    run_op("udf",       1'b0, -30, 0,  -1, 0, 1'b1, 1'b0, 0, 0, 0, 0);
    run_op("div_zero",  1'b1,   3, 1,   2, 4, 1'b1, 0,    0, 0, 0, 1);
    run_op("zero_nar",  1'b0,   3, 1,   2, 4, 1'b1, 1'b1, 0, 1, 1, 0);
    run_op("mul_zero",  1'b0,   5, 3,  -4, 2, 1'b1, 1'b0, 0, 0, 0, 1);
    run_op("edge_max",  1'b0,  29, 7,   0, 1, 1'b0, 1'b0, 0, 0, 0, 0);
    run_op("edge_min",  1'b1, -30, 0,   0, 0, 1'b0, 1'b1, 0, 0, 0, 0);

    // Backpressure: outputs must hold bit-exactly while out_ready is low.
    bus.out_ready = 1'b0;
    present("bp", 1'b1, -7, 6, 12, 3, 1'b1, 1'b1, 0, 0, 0, 0, r);
    chk_outputs("bp", r);
    snap = {bus.scale_out, bus.k_out, bus.exp_out, bus.sign_out, bus.nar_out,
            bus.zero_out, bus.ovf, bus.udf, 6'd0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp.hold", {bus.scale_out, bus.k_out, bus.exp_out, bus.sign_out, bus.nar_out,
                      bus.zero_out, bus.ovf, bus.udf, 6'd0}, snap);
      chk("bp.in_ready",  {31'd0, bus.in_ready},  32'd0);
      chk("bp.out_valid", {31'd0, bus.out_valid}, 32'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.release_idle", {31'd0, bus.in_ready},  32'd1);
    chk("bp.release_ov",   {31'd0, bus.out_valid}, 32'd0);

    // Reset while in COMBINE: operation dropped, no out_valid ever appears.
    bus.op = 1'b0; bus.k_A = 6'd4; bus.k_B = 6'd2; bus.in_valid = 1'b1;
    @(posedge clk); #1;   // accepted -> LOAD
    bus.in_valid = 1'b0;
    @(posedge clk); #1;   // COMBINE
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid.in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("rst_mid.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk_outputs("rst_mid", '0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) cnt++;
    end
    chk("rst_mid.no_valid", cnt, 0);

    for (int i = 0; i < 40; i++) begin
      int   ka, kb, ea, eb;
      bit   sp;
      ka = int'($urandom_range(60)) - 30;
      kb = int'($urandom_range(60)) - 30;
      ea = int'($urandom_range(7));
      eb = int'($urandom_range(7));
      sp = ($urandom_range(7) == 0);
      run_op($sformatf("rnd%0d", i), 1'($urandom), ka, ea, kb, eb, 1'($urandom), 1'($urandom),
             sp && $urandom_range(3) == 0, sp && $urandom_range(3) == 0,
             sp && $urandom_range(1) == 0, sp && $urandom_range(1) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
